// File: rtl/pipeline_ctrl_seq.sv
// pipeline_ctrl_seq: central stall/flush sequencer for the 5-stage pipeline.
// It combines four things into per-stage write enables and flushes:
//   - ID load-use hazard detection
//   - EX taken-branch flush
//   - multi-cycle mul/div occupancy, guarded by a watchdog
//   - data-memory wait states
// All control outputs are combinational from the current state and the inputs.
// The FSM state, the mul/div watchdog counter and the stall counter are registered.
//
// Data-memory handshake: the MEM stage holds DMem_Req high for the whole access.
// The access completes on the cycle where DMem_Req and DMem_Ready are both high.
// Any cycle with DMem_Req=1 and DMem_Ready=0 is a wait state. A wait state freezes
// every pipeline register and holds the FSM.
module pipeline_ctrl_seq #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1,
  input  logic [4:0]       Rs2,
  input  logic [4:0]       IDEX_Rd,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_MulDiv,
  input  logic             Branch_Taken,
  input  logic             MD_Done,
  input  logic             DMem_Req,
  input  logic             DMem_Ready,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic             MD_Start,
  output logic             Err,
  output logic [CNT_W-1:0] Stall_Cycles,
  output logic [1:0]       o_dbg_state
);

  localparam int MDC_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [MDC_W-1:0] MD_MAX = MDC_W'(MD_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_ERROR   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [MDC_W-1:0]   r_md_cnt;
  logic [MDC_W-1:0]   w_md_next;
  logic [CNT_W-1:0]   r_stall;
  logic               w_memwait;
  logic               w_load_use;

  // Register x0 is hardwired to zero, so a dependency on it is never a hazard.
  assign w_memwait  = DMem_Req & ~DMem_Ready;
  assign w_load_use = IDEX_MemRead & (IDEX_Rd != 5'd0) &
                      ((IDEX_Rd == Rs1) | (IDEX_Rd == Rs2));

  assign Stall_Cycles = r_stall;
  assign o_dbg_state  = r_state;

  // Next-state, watchdog-counter next value and all control outputs.
  always_comb begin
    w_next      = r_state;
    w_md_next   = r_md_cnt;
    PCWrite     = 1'b0;
    IFIDWrite   = 1'b0;
    IDEXWrite   = 1'b0;
    EXMEMWrite  = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    MD_Start    = 1'b0;
    Err         = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_RUN: begin
          if (w_memwait) begin
            // Freeze everything while memory is busy.
          end else if (IDEX_MulDiv) begin
            // Hold the mul/div in EX and let a bubble flow into MEM.
            MD_Start    = 1'b1;
            EXMEMWrite  = 1'b1;
            EXMEM_Flush = 1'b1;
            w_next      = ST_MD_BUSY;
            w_md_next   = MDC_W'(1);
          end else if (Branch_Taken) begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IDEXWrite  = 1'b1;
            EXMEMWrite = 1'b1;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
          end else if (w_load_use) begin
            // Insert one bubble. Next cycle the load has moved on to MEM.
            IDEXWrite  = 1'b1;
            IDEX_Flush = 1'b1;
            EXMEMWrite = 1'b1;
          end else begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IDEXWrite  = 1'b1;
            EXMEMWrite = 1'b1;
          end
        end
        ST_MD_BUSY: begin
          // The watchdog keeps counting through memory wait states.
          if (r_md_cnt < MD_MAX) w_md_next = r_md_cnt + MDC_W'(1);
          if (w_memwait) begin
            // Hold the state, keep all enables low.
          end else if (MD_Done) begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IDEXWrite  = 1'b1;
            EXMEMWrite = 1'b1;
            w_next     = ST_RUN;
            w_md_next  = '0;
          end else begin
            EXMEMWrite  = 1'b1;
            EXMEM_Flush = 1'b1;
            if (r_md_cnt >= MD_MAX) w_next = ST_ERROR;
          end
        end
        ST_ERROR: begin
          Err = 1'b1;
        end
        default: begin
          w_next = ST_ERROR;
        end
      endcase
    end
  end

  // State, watchdog counter and saturating stall counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_md_cnt <= '0;
      r_stall  <= '0;
    end else begin
      r_state  <= w_next;
      r_md_cnt <= w_md_next;
      if (!PCWrite && (r_stall != {CNT_W{1'b1}})) r_stall <= r_stall + CNT_W'(1);
    end
  end

endmodule
